// File: rtl/melody_pkg.sv
// Shared types for the melody sequencer: FSM states, song memory entry layout
// and counter sizing helper.
package melody_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        PLAY,
        GAP,
        DONE
    } state_t;

    typedef struct packed {
        logic [7:0] note;
        logic [3:0] beats;
    } song_entry_t;

    localparam logic [3:0] END_BEATS = 4'd0;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/melody_sequencer_tone_gen.sv
// Square-wave generator: toggles spkr every maxcount clocks while enabled,
// holds it low otherwise.
module tone_gen (
    input  logic        CLK,
    input  logic        RST,
    input  logic        en,
    input  logic [15:0] maxcount,
    output logic        spkr
);

    logic [15:0] tone_cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tone_cnt <= '0;
            spkr     <= 1'b0;
        end else if (!en || maxcount == 16'd0) begin
            tone_cnt <= '0;
            spkr     <= 1'b0;
        end else if (tone_cnt >= maxcount - 16'd1) begin
            tone_cnt <= '0;
            spkr     <= ~spkr;
        end else begin
            tone_cnt <= tone_cnt + 16'd1;
        end
    end

endmodule

// File: rtl/melody_sequencer.sv
// Song sequencer: walks the song memory, drives note_select to the lookup
// and plays each note for its beat count followed by a silent gap.
module melody_sequencer
    import melody_pkg::*;
#(
    parameter int DEPTH          = 32,
    parameter int ADDR_W         = 5,
    parameter int TICKS_PER_BEAT = 12_500_000,
    parameter int GAP_TICKS      = 1_000_000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [11:0]       wr_data,
    input  logic [15:0]       maxcount,
    output logic [7:0]        note_select,
    output logic              spkr,
    output logic              busy,
    output logic              done
);

    localparam int TW = cnt_w(TICKS_PER_BEAT);
    localparam int GW = cnt_w(GAP_TICKS);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_BEAT - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_TICKS - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    song_entry_t mem [DEPTH];
    song_entry_t entry;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] addr, addr_nx;
    logic [7:0]        note_nx;
    logic              busy_nx, done_nx;
    logic [3:0]        beat_cnt, beat_nx;
    logic [TW-1:0]     tick_cnt, tick_nx;
    logic [GW-1:0]     gap_cnt, gap_nx;
    logic              advance;
    logic              tone_en;

    always_ff @(posedge CLK) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    assign entry = mem[addr];

    always_comb begin
        state_nx = state;
        addr_nx  = addr;
        note_nx  = note_select;
        busy_nx  = busy;
        done_nx  = 1'b0;
        beat_nx  = beat_cnt;
        tick_nx  = tick_cnt;
        gap_nx   = gap_cnt;
        advance  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_nx = FETCH;
                    addr_nx  = '0;
                    busy_nx  = 1'b1;
                end
            end
            FETCH: begin
                if (entry.beats == END_BEATS) begin
                    if (loop_en && addr != '0) begin
                        addr_nx = '0;
                    end else begin
                        state_nx = DONE;
                        done_nx  = 1'b1;
                        busy_nx  = 1'b0;
                    end
                end else begin
                    state_nx = PLAY;
                    note_nx  = entry.note;
                    beat_nx  = entry.beats;
                    tick_nx  = '0;
                end
            end
            PLAY: begin
                if (tick_cnt == TICK_LAST) begin
                    tick_nx = '0;
                    if (beat_cnt == 4'd1) begin
                        note_nx = '0;
                        gap_nx  = '0;
                        if (GAP_TICKS == 0) advance = 1'b1;
                        else state_nx = GAP;
                    end else begin
                        beat_nx = beat_cnt - 4'd1;
                    end
                end else begin
                    tick_nx = tick_cnt + 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) advance = 1'b1;
                else gap_nx = gap_cnt + 1'b1;
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        // running off the last entry counts as hitting an end marker
        if (advance) begin
            if (addr == LAST_ADDR) begin
                addr_nx = '0;
                if (loop_en) begin
                    state_nx = FETCH;
                end else begin
                    state_nx = DONE;
                    done_nx  = 1'b1;
                    busy_nx  = 1'b0;
                end
            end else begin
                addr_nx  = addr + 1'b1;
                state_nx = FETCH;
            end
        end
        if (stop && state inside {FETCH, PLAY, GAP}) begin
            state_nx = IDLE;
            note_nx  = '0;
            busy_nx  = 1'b0;
            done_nx  = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            addr        <= '0;
            note_select <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            beat_cnt    <= '0;
            tick_cnt    <= '0;
            gap_cnt     <= '0;
        end else begin
            state       <= state_nx;
            addr        <= addr_nx;
            note_select <= note_nx;
            busy        <= busy_nx;
            done        <= done_nx;
            beat_cnt    <= beat_nx;
            tick_cnt    <= tick_nx;
            gap_cnt     <= gap_nx;
        end
    end

    // tone runs only while staying in PLAY so spkr drops with note_select
    assign tone_en = (state == PLAY) && (state_nx == PLAY);

    tone_gen u_tone (
        .CLK      (CLK),
        .RST      (RST),
        .en       (tone_en),
        .maxcount (maxcount),
        .spkr     (spkr)
    );

endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer: per-cycle trace check against a song-level
// model, with a stubbed note lookup.
module tb_melody_sequencer;

    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;
    localparam int TPB    = 4;
    localparam int GAP    = 2;

    localparam logic [10:0] BUSY_V = 11'b000_0000_0010;
    localparam logic [10:0] DONE_V = 11'b000_0000_0001;
    localparam logic [10:0] IDLE_V = 11'b000_0000_0000;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic              loop_en = 1'b0;
    logic              wr_en = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [11:0]       wr_data = '0;
    logic [15:0]       maxcount;
    logic [7:0]        note_select;
    logic              spkr, busy, done;
    logic [10:0]       obs;

    int n_cmp = 0;
    int n_bad = 0;

    logic [11:0] song [DEPTH];
    logic [10:0] exp_q [$];

    function automatic logic [15:0] lut(input logic [7:0] n);
        if (n == 8'd0 || n >= 8'd200) return 16'd0;
        return 16'(int'(n) % 5) + 16'd2;
    endfunction

    assign maxcount = lut(note_select);
    assign obs = {note_select, spkr, busy, done};

    melody_sequencer #(
        .DEPTH          (DEPTH),
        .ADDR_W         (ADDR_W),
        .TICKS_PER_BEAT (TPB),
        .GAP_TICKS      (GAP)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .start       (start),
        .stop        (stop),
        .loop_en     (loop_en),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .maxcount    (maxcount),
        .note_select (note_select),
        .spkr        (spkr),
        .busy        (busy),
        .done        (done)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic wr(input int a, input logic [11:0] d);
        @(negedge CLK);
        wr_en = 1'b1;
        wr_addr = ADDR_W'(a);
        wr_data = d;
        song[a] = d;
        @(negedge CLK);
        wr_en = 1'b0;
    endtask

    // expected {note, spkr, busy, done} after each edge, from start's edge on
    function automatic void build(input bit lp, input int cap);
        int a, bt, mc;
        logic [7:0] nt;
        logic [11:0] e;
        bit sp;
        exp_q.delete();
        a = 0;
        exp_q.push_back(BUSY_V);
        while (exp_q.size() < cap) begin
            e = song[a];
            nt = e[11:4];
            bt = int'(e[3:0]);
            if (bt == 0) begin
                if (lp && a != 0) begin
                    a = 0;
                    exp_q.push_back(BUSY_V);
                end else begin
                    exp_q.push_back(DONE_V);
                    exp_q.push_back(IDLE_V);
                    return;
                end
            end else begin
                mc = int'(lut(nt));
                for (int k = 0; k < bt * TPB; k++) begin
                    sp = (mc != 0) && (((k / mc) % 2) == 1);
                    exp_q.push_back({nt, sp, 2'b10});
                end
                for (int g = 0; g < GAP; g++) exp_q.push_back(BUSY_V);
                if (a == DEPTH - 1) begin
                    a = 0;
                    if (lp) begin
                        exp_q.push_back(BUSY_V);
                    end else begin
                        exp_q.push_back(DONE_V);
                        exp_q.push_back(IDLE_V);
                        return;
                    end
                end else begin
                    a++;
                    exp_q.push_back(BUSY_V);
                end
            end
        end
    endfunction

    task automatic play(input bit lp, input int cap, input int stop_at,
                        input int poke_at, input int wr_at, input int wa,
                        input logic [11:0] wd);
        build(lp, cap);
        @(negedge CLK);
        start = 1'b1;
        loop_en = lp;
        @(negedge CLK);
        start = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            chk("trace", 32'(obs), 32'(exp_q[i]));
            if (i == stop_at) begin
                start = 1'b0;
                wr_en = 1'b0;
                stop = 1'b1;
                @(negedge CLK);
                stop = 1'b0;
                chk("stop", 32'(obs), 32'(IDLE_V));
                repeat (3) begin
                    @(negedge CLK);
                    chk("stop_idle", 32'(obs), 32'(IDLE_V));
                end
                return;
            end
            start = (i == poke_at);
            wr_en = (i == wr_at);
            wr_addr = ADDR_W'(wa);
            wr_data = wd;
            @(negedge CLK);
        end
        start = 1'b0;
        wr_en = 1'b0;
    endtask

    initial begin
        int cnt, len, st, pk;
        bit lp;

        repeat (2) @(negedge CLK);
        chk("rst_outputs", 32'(obs), 32'(IDLE_V));
        RST = 1'b0;
        @(negedge CLK);
        chk("rst_idle", 32'(obs), 32'(IDLE_V));

        // two notes then end marker: done 21 cycles after start
        wr(0, {8'd1, 4'd2});
        wr(1, {8'd13, 4'd1});
        wr(2, 12'h000);
        @(negedge CLK);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        cnt = 2;
        while (done !== 1'b1 && cnt < 100) begin
            @(negedge CLK);
            cnt++;
        end
        chk("done_latency", cnt, 21);
        chk("busy_with_done", 32'(busy), 0);
        @(negedge CLK);
        chk("done_one_cycle", 32'(done), 0);
        play(1'b0, 1000, -1, 5, -1, 0, 12'h0);

        // tone timing, rest note, unknown note
        wr(0, {8'd1, 4'd2});
        wr(1, {8'd0, 4'd1});
        wr(2, {8'd200, 4'd1});
        wr(3, 12'h000);
        play(1'b0, 1000, -1, -1, -1, 0, 12'h0);

        // async reset mid-play, no clock edge
        @(negedge CLK);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (3) @(negedge CLK);
        #2 RST = 1'b1;
        #1 chk("async_rst", 32'(obs), 32'(IDLE_V));
        @(negedge CLK);
        RST = 1'b0;
        repeat (2) begin
            @(negedge CLK);
            chk("post_rst", 32'(obs), 32'(IDLE_V));
        end

        // looping single note, stopped mid-play
        wr(0, {8'd5, 4'd1});
        wr(1, 12'h000);
        play(1'b1, 40, 20, -1, -1, 0, 12'h0);

        // empty song with loop_en
        wr(0, 12'h000);
        play(1'b1, 10, -1, -1, -1, 0, 12'h0);

        // full memory, no marker: ends after the last entry, or wraps
        for (int a = 0; a < DEPTH; a++)
            wr(a, {8'($urandom_range(1, 199)), 4'd1});
        play(1'b0, 5000, -1, -1, -1, 0, 12'h0);
        play(1'b1, 260, 250, -1, -1, 0, 12'h0);

        // start and stop together in IDLE
        @(negedge CLK);
        start = 1'b1;
        stop = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        stop = 1'b0;
        chk("start_stop", 32'(obs), 32'(IDLE_V));
        @(negedge CLK);
        chk("start_stop_hold", 32'(obs), 32'(IDLE_V));

        // rewrite entry 1 while entry 0 plays
        wr(0, {8'd3, 4'd2});
        wr(1, {8'd9, 4'd1});
        wr(2, 12'h000);
        song[1] = {8'd17, 4'd2};
        play(1'b0, 1000, -1, -1, 3, 1, {8'd17, 4'd2});

        // random songs
        repeat (12) begin
            len = $urandom_range(1, 5);
            for (int a = 0; a < len; a++)
                wr(a, {8'($urandom_range(0, 255)), 4'($urandom_range(1, 3))});
            wr(len, 12'h000);
            lp = 1'($urandom_range(0, 1));
            pk = $urandom_range(1, 7);
            if (lp) begin
                st = $urandom_range(0, 70);
                play(1'b1, 80, st, pk, -1, 0, 12'h0);
            end else begin
                st = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : -1;
                play(1'b0, 1000, st, pk, -1, 0, 12'h0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/melody_sequencer.md
Name: melody_sequencer

Overview:
- Plays a programmed song through the existing note-to-maxcount lookup and the Basys 3 speaker pin.
- Steps through a small song memory, holding each note for a number of beats with a fixed silent gap between notes.
- Drives note_select to the lookup, takes maxcount back, and generates the square wave itself.
- Sits between the MCU output-port/switch logic and the speaker pin; runs on the 100 MHz board clock.

Parameters:
- DEPTH, 32: song entries; power of two.
- ADDR_W, 5: log2(DEPTH).
- TICKS_PER_BEAT, 12_500_000: clocks per beat (8 beats/s).
- GAP_TICKS, 1_000_000: silent clocks between notes (10 ms).

Ports:
- CLK  in  1  100 MHz clock
- RST  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins playback from entry 0
- stop  in  1  one-cycle pulse; aborts playback
- loop_en  in  1  sampled at end marker; 1 = restart at entry 0
- wr_en  in  1  song memory write strobe
- wr_addr  in  ADDR_W  write address
- wr_data  in  12  {note[11:4], beats[3:0]}
- maxcount  in  16  half-period count from the lookup, combinational on note_select
- note_select  out  8  registered note index to the lookup; 0 = rest
- spkr  out  1  registered square wave to the speaker pin
- busy  out  1  high while playing
- done  out  1  one-cycle pulse on natural song end

Behaviour:
- Reset (async, active-high): state=IDLE; addr=0; note_select=0, spkr=0, busy=0, done=0; all counters 0. Song memory is not reset.
- Memory: DEPTH x 12, synchronous write, combinational read.
  - A write at any time takes effect the next time that entry is fetched.
  - An entry with beats==0 is the end marker.
- IDLE: start and not stop -> FETCH with addr=0, busy=1. Otherwise stay in IDLE.
- FETCH (1 cycle): reads mem[addr].
  - End marker, loop_en=1, addr!=0 -> addr=0, FETCH.
  - End marker otherwise -> DONE. This guarantees an empty song never hangs.
  - Otherwise -> PLAY; note_select=note, beat_cnt=beats, tick_cnt=0.
- PLAY: note held for exactly beats*TICKS_PER_BEAT cycles. Then -> GAP with note_select=0.
- GAP: exactly GAP_TICKS cycles. Then addr+1 -> FETCH.
  - Past entry DEPTH-1, behave as if an end marker was fetched; addr wraps to 0.
- Per-note period: 1 + beats*TICKS_PER_BEAT + GAP_TICKS cycles.
- DONE (1 cycle): done=1, busy=0 -> IDLE.
- stop in FETCH/PLAY/GAP:
  - Next cycle: IDLE, note_select=0, spkr=0, busy=0, no done pulse.
  - stop beats start in the same cycle; start while busy is ignored.
- Tone generation (PLAY only):
  - tone_cnt clears on PLAY entry.
  - If maxcount!=0: counts 0..maxcount-1; on maxcount-1 it wraps and toggles spkr.
  - Resulting frequency = 100 MHz/(2*maxcount).
  - maxcount==0 (rest or unknown note): spkr held 0.
  - Outside PLAY: spkr forced 0 the next cycle.
- Widths:
  - tick_cnt is sized to hold TICKS_PER_BEAT-1.
  - beat_cnt is 4 bits.
  - GAP_TICKS==0 is legal: GAP lasts 0 cycles and PLAY goes straight to FETCH.

Decomposition:
- Package melody_pkg:
  - state enum {IDLE, FETCH, PLAY, GAP, DONE}
  - packed struct song_entry_t {note[7:0], beats[3:0]}
  - END_BEATS=0
- Sub-module tone_gen:
  - Inputs: CLK, RST, en, maxcount.
  - Output: spkr.
  - Contains the tone_cnt counter and toggle flop.

Test Plan (TICKS_PER_BEAT=4, GAP_TICKS=2, lookup stubbed):
1. Assert RST mid-PLAY with no clock edge -> note_select, spkr, busy, done go to 0 immediately; after release, state is IDLE.
2. Write {1,2},{13,1},{0,0}; pulse start -> FETCH 1 cycle; note_select=1 for 8 cycles; 0 for 2; FETCH; 13 for 4 cycles; 0 for 2; FETCH; done=1 for 1 cycle; busy falls with done. Total 21 cycles from start to done.
3. Stub maxcount=3 for note 1 -> spkr toggles every 3 cycles, starting low, during PLAY; entry {0,1} gives spkr=0 for its 4 cycles.
4. Song {5,1},{0,0} with loop_en=1 -> note_select repeats 5, no done; pulse stop mid-PLAY -> next cycle note_select=0, spkr=0, busy=0, no done.
5. Entry 0 = {0,0} with loop_en=1 -> done after a single FETCH. All DEPTH entries non-zero beats -> after entry DEPTH-1 plays, done pulses.
6. start and stop in the same IDLE cycle -> stays IDLE, busy=0. Write entry 1 while entry 0 plays -> new value plays.
